// File: rtl/nv_nvdla_pdp_wdma_atom_packer.sv
// rtl/nv_nvdla_pdp_wdma_atom_packer.sv - packs pairs of 64-bit PDP atoms into 128-bit WDMA write beats
module nv_nvdla_pdp_wdma_atom_packer #(
  parameter int ATOM_W = 64,
  parameter int CNT_W  = 13
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                reg2dp_op_en,
  input  logic [CNT_W-1:0]    cfg_line_atoms,
  input  logic [CNT_W-1:0]    cfg_line_num,
  input  logic                pdp_dp2wdma_valid,
  output logic                pdp_dp2wdma_ready,
  input  logic [ATOM_W-1:0]   pdp_dp2wdma_pd,
  output logic                dma_wr_valid,
  input  logic                dma_wr_ready,
  output logic [2*ATOM_W-1:0] dma_wr_data,
  output logic [1:0]          dma_wr_mask,
  output logic                dma_wr_line_end,
  output logic                packer_done,
  output logic                packer_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   atom_cnt;
  logic [CNT_W-1:0]   line_cnt;
  logic [CNT_W-1:0]   cfg_atoms_q;
  logic [CNT_W-1:0]   cfg_lines_q;
  logic [ATOM_W-1:0]  lo_data;
  logic               lo_vld;

  logic line_last;
  logic surf_last;
  logic completes;
  logic out_free;
  logic accept;
  logic out_take;

  assign line_last = (atom_cnt == cfg_atoms_q);
  assign surf_last = line_last & (line_cnt == cfg_lines_q);
  assign completes = lo_vld | line_last;
  assign out_free  = !dma_wr_valid | dma_wr_ready;
  assign out_take  = dma_wr_valid & dma_wr_ready;

  // A completing atom can only enter when the output register can take the beat.
  assign pdp_dp2wdma_ready = (state == RUN) & (!completes | out_free);
  assign accept            = pdp_dp2wdma_valid & pdp_dp2wdma_ready;

  assign packer_done = (state == DRAIN) & out_take;
  assign packer_busy = (state != IDLE);

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state           <= IDLE;
      atom_cnt        <= '0;
      line_cnt        <= '0;
      cfg_atoms_q     <= '0;
      cfg_lines_q     <= '0;
      lo_data         <= '0;
      lo_vld          <= 1'b0;
      dma_wr_valid    <= 1'b0;
      dma_wr_data     <= '0;
      dma_wr_mask     <= 2'b00;
      dma_wr_line_end <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reg2dp_op_en) begin
            state       <= RUN;
            atom_cnt    <= '0;
            line_cnt    <= '0;
            lo_vld      <= 1'b0;
            cfg_atoms_q <= cfg_line_atoms;
            cfg_lines_q <= cfg_line_num;
          end
        end
        RUN: begin
          if (accept && surf_last) state <= DRAIN;
        end
        DRAIN: begin
          if (out_take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (line_last) begin
          atom_cnt <= '0;
          line_cnt <= line_cnt + CNT_ONE;
        end else begin
          atom_cnt <= atom_cnt + CNT_ONE;
        end
        if (completes) begin
          lo_vld <= 1'b0;
        end else begin
          lo_vld  <= 1'b1;
          lo_data <= pdp_dp2wdma_pd;
        end
      end

      // Reload may coincide with the current beat leaving, giving one beat per two atoms.
      if (accept && completes) begin
        dma_wr_valid    <= 1'b1;
        dma_wr_data     <= lo_vld ? {pdp_dp2wdma_pd, lo_data} : {{ATOM_W{1'b0}}, pdp_dp2wdma_pd};
        dma_wr_mask     <= lo_vld ? 2'b11 : 2'b01;
        dma_wr_line_end <= line_last;
      end else if (dma_wr_ready) begin
        dma_wr_valid <= 1'b0;
      end
    end
  end

endmodule
